// File: rtl/regfile_sb_if.sv
// Register file port bundle: writeback, issue and two read ports.
// Master drives requests, slave returns read data and scoreboard state.
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             rd_en1;
  logic             rd_en2;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             rd_busy1;
  logic             rd_busy2;
  logic [CW-1:0]    busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data,
    output issue_en, issue_addr,
    output rd_en1, rd_en2,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2,
    input  rd_busy1, rd_busy2,
    input  busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  issue_en, issue_addr,
    input  rd_en1, rd_en2,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2,
    output rd_busy1, rd_busy2,
    output busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a per-register
// busy scoreboard for RAW hazard detection at decode.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  logic wr_ok;
  logic iss_ok;
  logic same;
  logic clr;
  logic inc;
  logic dec;

  assign wr_ok  = bus.wr_en &&
                  !(ZERO_REG && (bus.wr_addr == '0));
  assign iss_ok = bus.issue_en &&
                  !(ZERO_REG && (bus.issue_addr == '0));
  assign same   = bus.wr_addr == bus.issue_addr;

  // The newer producer wins when write and issue collide.
  assign clr = wr_ok && !(iss_ok && same);
  assign inc = iss_ok && !busy[bus.issue_addr];
  assign dec = clr && busy[bus.wr_addr];

  always_comb begin
    busy_nxt = busy;
    if (clr)
      busy_nxt[bus.wr_addr] = 1'b0;
    if (iss_ok)
      busy_nxt[bus.issue_addr] = 1'b1;
  end

  assign cnt_nxt = cnt + CW'(inc) - CW'(dec);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok)
        regs[bus.wr_addr] <= bus.wr_data;
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = cnt;

  logic             ren   [2];
  logic [AW-1:0]    raddr [2];
  logic [WIDTH-1:0] rdata [2];
  logic             rbusy [2];

  assign ren[0]   = bus.rd_en1;
  assign ren[1]   = bus.rd_en2;
  assign raddr[0] = bus.rd_addr1;
  assign raddr[1] = bus.rd_addr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zr;
    logic hit;

    assign zr  = ZERO_REG && (raddr[p] == '0);
    assign hit = wr_ok && (bus.wr_addr == raddr[p]);

    always_comb begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (ren[p] && !zr) begin
        rdata[p] = hit ? bus.wr_data : regs[raddr[p]];
        rbusy[p] = busy[raddr[p]] && !hit;
      end
    end
  end

  assign bus.rd_data1 = rdata[0];
  assign bus.rd_data2 = rdata[1];
  assign bus.rd_busy1 = rbusy[0];
  assign bus.rd_busy2 = rbusy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reference model plus literal checks,
// with a second 32x32 build for gating and full-scoreboard cases.
module tb_regfile_sb;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  regfile_sb_if #(.WIDTH(16), .DEPTH(16)) ifa ();
  regfile_sb_if #(.WIDTH(32), .DEPTH(32)) ifb ();

  regfile_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model of the 16x16 instance
  logic [15:0] m_regs [16];
  bit          m_busy [16];

  function automatic bit wr_hit(input logic [3:0] a);
    return ifa.wr_en && ifa.wr_addr != 0 && ifa.wr_addr == a;
  endfunction

  function automatic logic [15:0] exp_data(input logic e,
                                           input logic [3:0] a);
    if (!e || a == 0) return 16'h0;
    if (wr_hit(a)) return ifa.wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic e,
                                    input logic [3:0] a);
    if (!e || a == 0) return 1'b0;
    return m_busy[a] && !wr_hit(a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++)
      if (m_busy[i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (ifa.wr_en && ifa.wr_addr != 0) begin
        m_regs[ifa.wr_addr] = ifa.wr_data;
        m_busy[ifa.wr_addr] = 1'b0;
      end
      if (ifa.issue_en && ifa.issue_addr != 0)
        m_busy[ifa.issue_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_data1", 32'(ifa.rd_data1),
          32'(exp_data(ifa.rd_en1, ifa.rd_addr1)));
      chk("m_data2", 32'(ifa.rd_data2),
          32'(exp_data(ifa.rd_en2, ifa.rd_addr2)));
      chk("m_busy1", 32'(ifa.rd_busy1),
          32'(exp_busy(ifa.rd_en1, ifa.rd_addr1)));
      chk("m_busy2", 32'(ifa.rd_busy2),
          32'(exp_busy(ifa.rd_en2, ifa.rd_addr2)));
      chk("m_cnt", 32'(ifa.busy_cnt), 32'(exp_cnt()));
    end
  end

  task automatic step(input logic rs, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd,
                      input logic ie, input logic [3:0] ia,
                      input logic e1, input logic [3:0] a1,
                      input logic e2, input logic [3:0] a2);
    @(posedge clk);
    #1;
    rst            = rs;
    ifa.wr_en      = we;
    ifa.wr_addr    = wa;
    ifa.wr_data    = wd;
    ifa.issue_en   = ie;
    ifa.issue_addr = ia;
    ifa.rd_en1     = e1;
    ifa.rd_addr1   = a1;
    ifa.rd_en2     = e2;
    ifa.rd_addr2   = a2;
    @(negedge clk);
    #1;
  endtask

  task automatic stepb(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    @(posedge clk);
    #1;
    ifb.wr_en      = we;
    ifb.wr_addr    = wa;
    ifb.wr_data    = wd;
    ifb.issue_en   = ie;
    ifb.issue_addr = ia;
    ifb.rd_en1     = e1;
    ifb.rd_addr1   = a1;
    ifb.rd_en2     = e2;
    ifb.rd_addr2   = a2;
    @(negedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    ifa.wr_en = 0; ifa.wr_addr = 0; ifa.wr_data = 0;
    ifa.issue_en = 0; ifa.issue_addr = 0;
    ifa.rd_en1 = 0; ifa.rd_addr1 = 0;
    ifa.rd_en2 = 0; ifa.rd_addr2 = 0;
    ifb.wr_en = 0; ifb.wr_addr = 0; ifb.wr_data = 0;
    ifb.issue_en = 0; ifb.issue_addr = 0;
    ifb.rd_en1 = 0; ifb.rd_addr1 = 0;
    ifb.rd_en2 = 0; ifb.rd_addr2 = 0;

    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd3, 0, 4'd0);
    chk("rst_cnt0", 32'(ifa.busy_cnt), 32'h0);
    chk("rst_data0", 32'(ifa.rd_data1), 32'h0);

    // Load reg 3 and mark it busy, then reset over a live write
    step(1, 1, 4'd3, 16'h1234, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 1, 4'd3, 1, 4'd3, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd3, 0, 4'd0);
    chk("pre_rst_data", 32'(ifa.rd_data1), 32'h1234);
    chk("pre_rst_busy", 32'(ifa.rd_busy1), 32'h1);
    chk("pre_rst_cnt", 32'(ifa.busy_cnt), 32'h1);
    step(0, 1, 4'd4, 16'h5555, 1, 4'd4, 1, 4'd3, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd3, 1, 4'd4);
    chk("rst_data3", 32'(ifa.rd_data1), 32'h0);
    chk("rst_busy3", 32'(ifa.rd_busy1), 32'h0);
    chk("rst_data4", 32'(ifa.rd_data2), 32'h0);
    chk("rst_busy4", 32'(ifa.rd_busy2), 32'h0);
    chk("rst_cnt", 32'(ifa.busy_cnt), 32'h0);

    step(1, 1, 4'd5, 16'hBEEF, 0, 4'd0, 1, 4'd5, 1, 4'd5);
    chk("byp_d1", 32'(ifa.rd_data1), 32'hBEEF);
    chk("byp_d2", 32'(ifa.rd_data2), 32'hBEEF);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd5, 1, 4'd5);
    chk("stored_d1", 32'(ifa.rd_data1), 32'hBEEF);
    chk("stored_d2", 32'(ifa.rd_data2), 32'hBEEF);

    step(1, 0, 4'd0, 16'h0, 1, 4'd7, 1, 4'd7, 0, 4'd0);
    chk("sb_c0_busy", 32'(ifa.rd_busy1), 32'h0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd7, 0, 4'd0);
    chk("sb_c1_busy", 32'(ifa.rd_busy1), 32'h1);
    chk("sb_c1_cnt", 32'(ifa.busy_cnt), 32'h1);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd7, 0, 4'd0);
    step(1, 1, 4'd7, 16'h0777, 0, 4'd0, 1, 4'd7, 0, 4'd0);
    chk("sb_c3_busy", 32'(ifa.rd_busy1), 32'h0);
    chk("sb_c3_data", 32'(ifa.rd_data1), 32'h0777);
    chk("sb_c3_cnt", 32'(ifa.busy_cnt), 32'h1);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd7, 0, 4'd0);
    chk("sb_c4_cnt", 32'(ifa.busy_cnt), 32'h0);

    step(1, 0, 4'd0, 16'h0, 1, 4'd2, 0, 4'd0, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd2, 0, 4'd0);
    chk("wi_pre_busy", 32'(ifa.rd_busy1), 32'h1);
    step(1, 1, 4'd2, 16'h2222, 1, 4'd2, 1, 4'd2, 0, 4'd0);
    chk("wi_byp", 32'(ifa.rd_data1), 32'h2222);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd2, 0, 4'd0);
    chk("wi_data", 32'(ifa.rd_data1), 32'h2222);
    chk("wi_busy", 32'(ifa.rd_busy1), 32'h1);
    chk("wi_cnt", 32'(ifa.busy_cnt), 32'h1);

    step(1, 1, 4'd2, 16'h3333, 1, 4'd9, 0, 4'd0, 0, 4'd0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd9, 1, 4'd2);
    chk("mix_busy9", 32'(ifa.rd_busy1), 32'h1);
    chk("mix_busy2", 32'(ifa.rd_busy2), 32'h0);
    chk("mix_cnt", 32'(ifa.busy_cnt), 32'h1);

    step(1, 1, 4'd0, 16'hFFFF, 1, 4'd0, 1, 4'd0, 1, 4'd0);
    chk("z_byp", 32'(ifa.rd_data1), 32'h0);
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd0, 0, 4'd0);
    chk("z_data", 32'(ifa.rd_data1), 32'h0);
    chk("z_busy", 32'(ifa.rd_busy1), 32'h0);
    chk("z_cnt", 32'(ifa.busy_cnt), 32'h1);

    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd9, 1, 4'd9);
    chk("gate_data", 32'(ifa.rd_data1), 32'h0);
    chk("gate_busy", 32'(ifa.rd_busy1), 32'h0);
    chk("ungated_busy", 32'(ifa.rd_busy2), 32'h1);

    // Mixed traffic pattern, model-checked every cycle
    for (int i = 0; i < 48; i++)
      step(i != 30, (i % 3) != 0, 4'(i * 5),
           16'(i * 257) ^ 16'h5A5A, (i % 2) == 0,
           4'(i * 3 + 1), (i % 5) != 0, 4'(i * 7),
           1'b1, 4'(i * 11));

    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

    stepb(1, 5'd17, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 32; i++)
      stepb(0, 5'd0, 32'h0, 1, 5'(i), 0, 5'd0, 0, 5'd0);
    stepb(0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd17, 1, 5'd17);
    chk("b_gate_data", ifb.rd_data1, 32'h0);
    chk("b_gate_busy", 32'(ifb.rd_busy1), 32'h0);
    chk("b_data", ifb.rd_data2, 32'hDEADBEEF);
    chk("b_busy", 32'(ifb.rd_busy2), 32'h1);
    chk("b_full_cnt", 32'(ifb.busy_cnt), 32'd31);
    stepb(1, 5'd5, 32'h5, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    chk("b_cnt_hold", 32'(ifb.busy_cnt), 32'd31);
    stepb(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd5, 0, 5'd0);
    chk("b_cnt_dec", 32'(ifb.busy_cnt), 32'd30);
    chk("b_data5", ifb.rd_data1, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a write-pending scoreboard, replacing the fixed 16-bit single-register bit-cell design in the WISC datapath. It holds DEPTH registers of WIDTH bits and provides one synchronous write port and two combinational read ports with write-through bypass. Per-register busy bits track in-flight producers between decode (issue) and writeback, so the decode stage can detect RAW hazards. Read outputs are driven actively; the block has no tri-state bitlines.

## Interface
- WIDTH, 16, data width of each register.
- DEPTH, 16, number of registers; must be a power of 2, at least 2.
- ZERO_REG, 1, when 1, register 0 reads as 0, and writes and issues to it are ignored.
- AW, log2(DEPTH), address width (derived; not overridden).
- CW, log2(DEPTH)+1, width of busy_cnt (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  marks issue_addr as pending (producer issued).
- issue_addr  in  AW  destination register of the issued instruction.
- rd_en1, rd_en2  in  1  read enables; a low enable forces the corresponding rd_data to 0.
- rd_addr1, rd_addr2  in  AW  read addresses.
- rd_data1, rd_data2  out  WIDTH  read data (combinational).
- rd_busy1, rd_busy2  out  1  the addressed register has an outstanding producer (combinational).
- busy_cnt  out  CW  number of registers whose busy bit is set (registered).

## Operation
- Storage: regs[DEPTH] of WIDTH bits; busy[DEPTH] of 1 bit.
- Write: when wr_en is high and the write is not suppressed (ZERO_REG=1 and wr_addr=0), regs[wr_addr] <= wr_data and busy[wr_addr] <= 0, unless the same-cycle issue targets the same address.
- Issue: when issue_en is high and the issue is not suppressed, busy[issue_addr] <= 1. Issue to an already-busy register (WAW) is legal; the bit stays 1.
- Simultaneous write and issue to the same address: regs is updated and busy ends at 1 (the newer producer wins).
- Read n: if rd_en_n = 0, output 0. Else if ZERO_REG=1 and addr=0, output 0. Else if the write is active and unsuppressed with wr_addr = rd_addr_n, output wr_data (bypass). Else output regs[rd_addr_n].
- rd_busy_n: 0 if rd_en_n = 0 or the address is the suppressed register 0. Otherwise busy[rd_addr_n] AND NOT(active write to the same address in this cycle). The current-cycle issue is not reflected; it becomes visible next cycle.
- Both read ports may address the same register, including the one being written; both see the bypassed value.
- busy_cnt equals the population count of busy after the update. It is maintained incrementally: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both happen on different addresses. It never exceeds DEPTH - ZERO_REG.

## Timing
- Reset (rst=0 at a clock edge): all regs <= 0, all busy <= 0, busy_cnt <= 0.
  - Resulting outputs: rd_data = 0 and rd_busy = 0 for any address.
  - Reset overrides wr_en and issue_en in the same cycle.
  - Reset mid-operation discards all pending state.
- Write latency: 0 cycles to the read ports via bypass; the stored value appears from cycle N+1.
- Issue latency: the busy bit is visible on rd_busy at cycle N+1.
- No handshake and no backpressure: every enable is accepted every cycle.

## Test plan
- Reset: load regs 3=0x1234 and busy 3, then assert rst=0 for one cycle -> rd_data1 at address 3 = 0x0000, rd_busy1 = 0, busy_cnt = 0.
- Bypass: wr_en with addr 5 and 0xBEEF, with rd_addr1 = rd_addr2 = 5 in the same cycle -> both rd_data = 0xBEEF in that cycle and after.
- Zero register (ZERO_REG=1): write 0xFFFF to 0 and issue to 0 -> rd_data = 0, rd_busy = 0, busy_cnt unchanged.
- Scoreboard: issue 7 at cycle 0 -> rd_busy 0 in cycle 0, 1 in cycle 1, busy_cnt = 1. Write 7 at cycle 3 -> rd_busy 0 in cycle 3, busy_cnt = 0 in cycle 4.
- Same-address write and issue: busy[2]=1, then write 2 and issue 2 together -> data updated, rd_busy 1 next cycle, busy_cnt unchanged.
- Read enable gating, plus DEPTH=32, WIDTH=32 build: rd_en1 = 0 on a nonzero register -> rd_data1 = 0 and rd_busy1 = 0. Fill all 31 busy bits -> busy_cnt = 31.
